// File: rtl/game_over_square_object.sv
// Position and drop/blink/hold animation for the game-over icon, plus the registered
// per-pixel inside test and bitmap offsets that feed gameOverBitMap.
module game_over_square_object #(
  parameter int unsigned SCALE_SHIFT   = 2,
  parameter int unsigned TOP_LEFT_X    = 256,
  parameter int unsigned START_Y       = 0,
  parameter int unsigned TARGET_Y      = 176,
  parameter int unsigned DROP_SPEED    = 8,
  parameter int unsigned BLINK_FRAMES  = 15,
  parameter int unsigned BLINK_TOGGLES = 6
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        gameOver,
  input  logic        restart,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        InsideRectangle,
  output logic [10:0] topLeftY,
  output logic        animDone
);

  localparam int unsigned Side    = 32 << SCALE_SHIFT;
  localparam int unsigned FrameW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned ToggleW = $clog2(BLINK_TOGGLES + 1);

  typedef enum logic [1:0] {StIdle, StDrop, StBlink, StHold} state_e;

  state_e              state_q, state_d;
  logic [10:0]         top_q, top_d;
  logic                visible_q, visible_d;
  logic [FrameW-1:0]   frame_q, frame_d;
  logic [ToggleW-1:0]  toggle_q, toggle_d;
  logic                game_over_q;
  logic [10:0]         offset_x_q, offset_x_d;
  logic [10:0]         offset_y_q, offset_y_d;
  logic                inside_q, inside_d;

  logic [11:0]         next_y;
  logic [11:0]         px12, py12, top12;
  logic [10:0]         dx, dy;
  logic                in_x, in_y;

  assign next_y = {1'b0, top_q} + 12'(DROP_SPEED);

  always_comb begin
    state_d   = state_q;
    top_d     = top_q;
    visible_d = visible_q;
    frame_d   = frame_q;
    toggle_d  = toggle_q;
    if (restart) begin
      state_d   = StIdle;
      visible_d = 1'b0;
      frame_d   = '0;
      toggle_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          visible_d = 1'b0;
          if (gameOver && !game_over_q) begin
            state_d   = StDrop;
            top_d     = 11'(START_Y);
            visible_d = 1'b1;
          end
        end
        StDrop: begin
          if (startOfFrame) begin
            if (next_y >= 12'(TARGET_Y)) begin
              state_d   = StBlink;
              top_d     = 11'(TARGET_Y);
              frame_d   = '0;
              toggle_d  = '0;
              visible_d = 1'b1;
            end else begin
              top_d = next_y[10:0];
            end
          end
        end
        StBlink: begin
          if (startOfFrame) begin
            if (frame_q == FrameW'(BLINK_FRAMES - 1)) begin
              frame_d   = '0;
              visible_d = ~visible_q;
              toggle_d  = toggle_q + ToggleW'(1);
              if ((toggle_q + ToggleW'(1)) == ToggleW'(BLINK_TOGGLES)) begin
                state_d   = StHold;
                visible_d = 1'b1;
              end
            end else begin
              frame_d = frame_q + FrameW'(1);
            end
          end
        end
        StHold: visible_d = 1'b1;
        default: state_d = StIdle;
      endcase
    end
  end

  // 12-bit compares so the right-hand bounds cannot wrap near the screen edge.
  always_comb begin
    px12       = {1'b0, pixelX};
    py12       = {1'b0, pixelY};
    top12      = {1'b0, top_q};
    in_x       = (px12 >= 12'(TOP_LEFT_X)) && (px12 < 12'(TOP_LEFT_X + Side));
    in_y       = (py12 >= top12) && (py12 < (top12 + 12'(Side)));
    inside_d   = in_x && in_y && visible_q;
    dx         = pixelX - 11'(TOP_LEFT_X);
    dy         = pixelY - top_q;
    offset_x_d = inside_d ? (dx >> SCALE_SHIFT) : 11'd0;
    offset_y_d = inside_d ? (dy >> SCALE_SHIFT) : 11'd0;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= StIdle;
      top_q       <= 11'(START_Y);
      visible_q   <= 1'b0;
      frame_q     <= '0;
      toggle_q    <= '0;
      game_over_q <= 1'b0;
      offset_x_q  <= '0;
      offset_y_q  <= '0;
      inside_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      top_q       <= top_d;
      visible_q   <= visible_d;
      frame_q     <= frame_d;
      toggle_q    <= toggle_d;
      game_over_q <= gameOver;
      offset_x_q  <= offset_x_d;
      offset_y_q  <= offset_y_d;
      inside_q    <= inside_d;
    end
  end

  assign offsetX         = offset_x_q;
  assign offsetY         = offset_y_q;
  assign InsideRectangle = inside_q;
  assign topLeftY        = top_q;
  assign animDone        = (state_q == StHold);

endmodule

// File: tb/tb_game_over_square_object.sv
// Scoreboard bench for game_over_square_object: pixel expectations are queued when driven
// and checked one cycle later; position/state outputs are checked directly.
module tb_game_over_square_object;

  logic        clk;
  logic        resetN;
  logic        startOfFrame;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        gameOver;
  logic        restart;
  logic [10:0] offsetX;
  logic [10:0] offsetY;
  logic        InsideRectangle;
  logic [10:0] topLeftY;
  logic        animDone;

  game_over_square_object dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .pixelX         (pixelX),
    .pixelY         (pixelY),
    .gameOver       (gameOver),
    .restart        (restart),
    .offsetX        (offsetX),
    .offsetY        (offsetY),
    .InsideRectangle(InsideRectangle),
    .topLeftY       (topLeftY),
    .animDone       (animDone)
  );

  typedef struct {
    int          due;
    logic        ins;
    logic [10:0] ox;
    logic [10:0] oy;
  } exp_t;

  exp_t sb_q[$];
  int   cyc;
  int   n_checks;
  int   n_fails;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      exp_t e;
      e = sb_q.pop_front();
      check_eq("inside", 32'(InsideRectangle), 32'(e.ins));
      check_eq("offX", 32'(offsetX), 32'(e.ox));
      check_eq("offY", 32'(offsetY), 32'(e.oy));
    end
  end

  // All tasks start and end at posedge+1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pixel(input int x, input int y, input logic ins, input int ox,
                             input int oy);
    exp_t e;
    pixelX = 11'(x);
    pixelY = 11'(y);
    e.due  = cyc + 1;
    e.ins  = ins;
    e.ox   = 11'(ox);
    e.oy   = 11'(oy);
    sb_q.push_back(e);
    tick();
  endtask

  task automatic sof_pulse();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 10; i++) begin
      if (sb_q.size() == 0) break;
      tick();
    end
    check_eq("drain", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic gameover_edge();
    gameOver = 1'b0;
    tick();
    gameOver = 1'b1;
    tick();
  endtask

  task automatic drop_all();
    for (int k = 1; k <= 22; k++) begin
      sof_pulse();
      check_eq("dropY", 32'(topLeftY), (k * 8 > 176) ? 32'd176 : 32'(k * 8));
      drive_pixel(256, (k * 8 > 176) ? 176 : k * 8, 1'b1, 0, 0);
    end
    wait_drain();
  endtask

  initial begin
    cyc          = 0;
    n_checks     = 0;
    n_fails      = 0;
    resetN       = 1'b1;
    startOfFrame = 1'b0;
    pixelX       = '0;
    pixelY       = '0;
    gameOver     = 1'b0;
    restart      = 1'b0;
    #1 resetN = 1'b0;
    #2;
    check_eq("rstInside", 32'(InsideRectangle), 32'd0);
    check_eq("rstOffX", 32'(offsetX), 32'd0);
    check_eq("rstOffY", 32'(offsetY), 32'd0);
    check_eq("rstDone", 32'(animDone), 32'd0);
    check_eq("rstY", 32'(topLeftY), 32'd0);
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;
    tick();

    // Idle: nothing drawn anywhere, including the icon area.
    for (int y = 0; y < 480; y += 40)
      for (int x = 0; x < 640; x += 40)
        drive_pixel(x, y, 1'b0, 0, 0);
    drive_pixel(300, 200, 1'b0, 0, 0);
    wait_drain();
    check_eq("idleDone", 32'(animDone), 32'd0);

    gameOver = 1'b1;
    tick();
    check_eq("dropStartY", 32'(topLeftY), 32'd0);
    drop_all();
    check_eq("blinkDone", 32'(animDone), 32'd0);

    // Boundaries in blink phase 0.
    drive_pixel(256, 176, 1'b1, 0, 0);
    drive_pixel(383, 303, 1'b1, 31, 31);
    drive_pixel(384, 303, 1'b0, 0, 0);
    drive_pixel(383, 304, 1'b0, 0, 0);
    drive_pixel(260, 180, 1'b1, 1, 1);
    drive_pixel(255, 176, 1'b0, 0, 0);
    drive_pixel(256, 175, 1'b0, 0, 0);
    wait_drain();

    for (int f = 1; f <= 90; f++) begin
      logic vis;
      sof_pulse();
      vis = (f == 90) ? 1'b1 : (((f / 15) % 2) == 0);
      if (vis) drive_pixel(300, 200, 1'b1, 11, 6);
      else     drive_pixel(300, 200, 1'b0, 0, 0);
      if (f == 89) check_eq("doneEarly", 32'(animDone), 32'd0);
    end
    wait_drain();
    check_eq("holdDone", 32'(animDone), 32'd1);

    gameOver_edge_in_hold : begin
      gameover_edge();
      check_eq("holdDone2", 32'(animDone), 32'd1);
      check_eq("holdY", 32'(topLeftY), 32'd176);
      drive_pixel(300, 200, 1'b1, 11, 6);
      wait_drain();
    end

    restart = 1'b1;
    tick();
    restart = 1'b0;
    check_eq("rstrtDone", 32'(animDone), 32'd0);
    check_eq("rstrtY", 32'(topLeftY), 32'd176);
    drive_pixel(300, 200, 1'b0, 0, 0);
    wait_drain();

    // Restart wins over a same-cycle frame step in DROP.
    gameover_edge();
    check_eq("drop2Y0", 32'(topLeftY), 32'd0);
    repeat (3) sof_pulse();
    check_eq("drop2Y", 32'(topLeftY), 32'd24);
    startOfFrame = 1'b1;
    restart      = 1'b1;
    tick();
    startOfFrame = 1'b0;
    restart      = 1'b0;
    check_eq("sameCycY", 32'(topLeftY), 32'd24);
    check_eq("sameCycDone", 32'(animDone), 32'd0);
    drive_pixel(300, 30, 1'b0, 0, 0);
    sof_pulse();
    check_eq("idleStepY", 32'(topLeftY), 32'd24);
    drive_pixel(300, 30, 1'b0, 0, 0);
    wait_drain();

    // Asynchronous reset in the middle of blinking.
    gameover_edge();
    drop_all();
    repeat (5) sof_pulse();
    drive_pixel(300, 200, 1'b1, 11, 6);
    wait_drain();
    #2 resetN = 1'b0;
    #1;
    check_eq("arstInside", 32'(InsideRectangle), 32'd0);
    check_eq("arstOffX", 32'(offsetX), 32'd0);
    check_eq("arstOffY", 32'(offsetY), 32'd0);
    check_eq("arstDone", 32'(animDone), 32'd0);
    check_eq("arstY", 32'(topLeftY), 32'd0);
    tick();
    resetN = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
